// File: rtl/pkt_pkg.sv
// Shared definitions for the packet framer and the downstream head/data/tail
// channel FSM, so both stages agree on state encodings and minimum length.
package pkt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } fr_state_e;

    localparam int PKT_MIN_LEN = 2;

    // Downstream channel FSM states, derived from valid/head/tail.
    typedef enum logic [1:0] {
        STATE_IDLE = 2'd0,
        STATE_HEAD = 2'd1,
        STATE_DATA = 2'd2,
        STATE_TAIL = 2'd3
    } ch_state_e;

endpackage

// File: rtl/pkt_framer_if.sv
// Command + framed-beat channel of the packet framer. The master side is the
// framer itself; the slave side is the command source / beat consumer.
interface pkt_framer_if #(
    parameter int LEN_W = 8,
    parameter int DW    = 8,
    parameter int CNT_W = 16
);
    import pkt_pkg::*;

    logic             cmd_valid;
    logic [LEN_W-1:0] cmd_len;
    logic             cmd_ready;
    logic             stall;
    logic             valid;
    logic             head;
    logic             tail;
    logic [DW-1:0]    data;
    logic             busy;
    logic [CNT_W-1:0] pkt_cnt;

    modport master (
        input  cmd_valid, cmd_len, stall,
        output cmd_ready, valid, head, tail, data, busy, pkt_cnt
    );

    modport slave (
        output cmd_valid, cmd_len, stall,
        input  cmd_ready, valid, head, tail, data, busy, pkt_cnt
    );

endinterface

// File: rtl/pkt_framer.sv
// Packet framer: turns a length command into a head/data.../tail beat train with
// registered channel outputs, optional stall bubbles and an inter-packet gap.
module pkt_framer
    import pkt_pkg::*;
#(
    parameter int LEN_W   = 8,
    parameter int DW      = 8,
    parameter int MIN_GAP = 0,
    parameter int CNT_W   = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    pkt_framer_if.master bus
);

    // Gap counter only has to hold MIN_GAP-1.
    localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

    fr_state_e        state_q, state_d;
    logic [LEN_W-1:0] beat_q, beat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             valid_q, valid_d;
    logic             head_q, head_d;
    logic             tail_q, tail_d;
    logic [DW-1:0]    data_q, data_d;
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic             last_beat;

    assign last_beat = (beat_q == len_q - LEN_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            len_q     <= '0;
            gap_cnt_q <= '0;
            valid_q   <= 1'b0;
            head_q    <= 1'b0;
            tail_q    <= 1'b0;
            data_q    <= '0;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            len_q     <= len_d;
            gap_cnt_q <= gap_cnt_d;
            valid_q   <= valid_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            data_q    <= data_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        len_d     = len_q;
        gap_cnt_d = gap_cnt_q;
        valid_d   = 1'b0;
        head_d    = 1'b0;
        tail_d    = 1'b0;
        data_d    = data_q;
        pkt_cnt_d = pkt_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    len_d   = (bus.cmd_len < LEN_W'(PKT_MIN_LEN)) ? LEN_W'(PKT_MIN_LEN)
                                                                  : bus.cmd_len;
                    beat_d  = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                // A stalled edge emits a bubble; beat and data are left untouched.
                if (!bus.stall) begin
                    valid_d = 1'b1;
                    head_d  = (beat_q == '0);
                    tail_d  = last_beat;
                    data_d  = DW'(beat_q);
                    beat_d  = beat_q + LEN_W'(1);
                    if (last_beat) begin
                        pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
                        if (MIN_GAP == 0) begin
                            state_d = IDLE;
                        end else begin
                            state_d   = GAP;
                            gap_cnt_d = GAP_W'(MIN_GAP - 1);
                        end
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == '0) state_d = IDLE;
                else                 gap_cnt_d = gap_cnt_q - GAP_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.valid     = valid_q;
    assign bus.head      = head_q;
    assign bus.tail      = tail_q;
    assign bus.data      = data_q;
    assign bus.pkt_cnt   = pkt_cnt_q;

endmodule

// File: tb/tb_pkt_framer.sv
// Bench for pkt_framer: two instances (MIN_GAP=0/CNT_W=16 and MIN_GAP=2/CNT_W=2)
// driven by directed and random stimulus, compared cycle by cycle to a packet-level model.
module tb_pkt_framer;
    import pkt_pkg::*;

    localparam int LEN_W = 8;
    localparam int DW    = 8;
    localparam int GAPS[2] = '{0, 2};
    localparam int CWS[2]  = '{16, 2};

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    pkt_framer_if #(.LEN_W(LEN_W), .DW(DW), .CNT_W(16)) bus0 ();
    pkt_framer_if #(.LEN_W(LEN_W), .DW(DW), .CNT_W(2))  bus1 ();

    pkt_framer #(.LEN_W(LEN_W), .DW(DW), .MIN_GAP(0), .CNT_W(16)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0));
    pkt_framer #(.LEN_W(LEN_W), .DW(DW), .MIN_GAP(2), .CNT_W(2)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1));

    // stimulus per instance
    logic             cv[2];
    logic [LEN_W-1:0] cl[2];
    logic             st[2];
    assign bus0.cmd_valid = cv[0];
    assign bus0.cmd_len   = cl[0];
    assign bus0.stall     = st[0];
    assign bus1.cmd_valid = cv[1];
    assign bus1.cmd_len   = cl[1];
    assign bus1.stall     = st[1];

    // observed outputs
    logic          ov[2], oh[2], ot[2], ordy[2], obsy[2];
    logic [DW-1:0] od[2];
    logic [15:0]   oc[2];
    assign ov[0] = bus0.valid;  assign ov[1] = bus1.valid;
    assign oh[0] = bus0.head;   assign oh[1] = bus1.head;
    assign ot[0] = bus0.tail;   assign ot[1] = bus1.tail;
    assign od[0] = bus0.data;   assign od[1] = bus1.data;
    assign ordy[0] = bus0.cmd_ready; assign ordy[1] = bus1.cmd_ready;
    assign obsy[0] = bus0.busy;      assign obsy[1] = bus1.busy;
    assign oc[0] = bus0.pkt_cnt;
    assign oc[1] = {14'd0, bus1.pkt_cnt};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d t=%0t", tag, act, exp, $time);
        end
    endtask

    // Packet-level model: beats still owed, beats already sent, idle cycles owed.
    int left[2], sent[2], hold[2], cnt[2];
    bit ev[2], eh[2], et[2];
    int ed[2];
    ch_state_e chs[2];

    function automatic bit m_ready(input int i);
        return (left[i] == 0) && (hold[i] == 0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            left[i] = 0; sent[i] = 0; hold[i] = 0; cnt[i] = 0;
            ev[i] = 0; eh[i] = 0; et[i] = 0; ed[i] = 0;
            chs[i] = STATE_IDLE;
        end
    endtask

    task automatic model_edge(input int i);
        ev[i] = 0; eh[i] = 0; et[i] = 0;
        if (left[i] > 0) begin
            if (!st[i]) begin
                ev[i] = 1;
                eh[i] = (sent[i] == 0);
                et[i] = (left[i] == 1);
                ed[i] = sent[i] % (1 << DW);
                sent[i]++;
                left[i]--;
                if (left[i] == 0) begin
                    cnt[i]  = (cnt[i] + 1) % (1 << CWS[i]);
                    hold[i] = GAPS[i];
                end
            end
        end else if (hold[i] > 0) begin
            hold[i]--;
        end else if (cv[i]) begin
            left[i] = (int'(cl[i]) < 2) ? 2 : int'(cl[i]);
            sent[i] = 0;
        end
    endtask

    task automatic compare(input int i);
        bit legal;
        ch_state_e nx;
        chk($sformatf("valid%0d", i), ov[i], ev[i]);
        chk($sformatf("head%0d", i), oh[i], eh[i]);
        chk($sformatf("tail%0d", i), ot[i], et[i]);
        chk($sformatf("data%0d", i), od[i], ed[i]);
        chk($sformatf("ready%0d", i), ordy[i], m_ready(i));
        chk($sformatf("busy%0d", i), obsy[i], !m_ready(i));
        chk($sformatf("pkt_cnt%0d", i), oc[i], cnt[i]);
        chk($sformatf("head_tail_excl%0d", i), oh[i] & ot[i], 0);
        // downstream channel FSM walk must stay legal
        legal = 1'b1;
        nx = chs[i];
        if (ov[i]) begin
            if (oh[i]) begin
                nx = STATE_HEAD; legal = (chs[i] == STATE_IDLE);
            end else if (ot[i]) begin
                nx = STATE_TAIL; legal = (chs[i] == STATE_HEAD) || (chs[i] == STATE_DATA);
            end else begin
                nx = STATE_DATA; legal = (chs[i] == STATE_HEAD) || (chs[i] == STATE_DATA);
            end
        end else if (chs[i] == STATE_TAIL) begin
            nx = STATE_IDLE;
        end
        chk($sformatf("chan_walk%0d", i), legal, 1);
        chs[i] = nx;
    endtask

    task automatic step();
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_edge(i);
        @(negedge clk);
        for (int i = 0; i < 2; i++) compare(i);
    endtask

    task automatic wait_ready(input int i);
        int n = 0;
        while (!m_ready(i) && n < 600) begin
            step();
            n++;
        end
        if (n >= 600) chk($sformatf("ready_timeout%0d", i), 0, 1);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            cv[i] = 0; cl[i] = '0; st[i] = 0;
        end
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) compare(i);
        @(negedge clk);
        reset_n = 1'b1;

        // len=3, no stall
        cv[0] = 1; cl[0] = 8'd3;
        step();
        cv[0] = 0; cl[0] = 8'd9;
        repeat (4) step();
        chk("t1_pkt_cnt", oc[0], 1);

        // len 0 and 1 clamp to 2
        cv[0] = 1; cl[0] = 8'd0;
        step();
        cv[0] = 0;
        wait_ready(0);
        cv[0] = 1; cl[0] = 8'd1;
        step();
        cv[0] = 0;
        wait_ready(0);
        chk("t2_pkt_cnt", oc[0], 3);

        // len=4, stall on the second SEND edge only
        cv[0] = 1; cl[0] = 8'd4;
        step();
        cv[0] = 0;
        step();
        st[0] = 1;
        step();
        chk("t3_bubble", ov[0], 0);
        st[0] = 0;
        wait_ready(0);
        step();

        // MIN_GAP=2 instance, command held, len=2; CNT_W=2 wraps
        cv[1] = 1; cl[1] = 8'd2;
        repeat (40) step();
        cv[1] = 0;
        wait_ready(1);
        step();

        // reset in the middle of a len=5 packet
        cv[0] = 1; cl[0] = 8'd5;
        step();
        cv[0] = 0;
        step();
        chk("t5_head_seen", oh[0], 1);
        reset_n = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) compare(i);
        @(negedge clk);
        reset_n = 1'b1;
        cv[0] = 1; cl[0] = 8'd2;
        step();
        cv[0] = 0;
        step();
        chk("t5_restart_head", oh[0], 1);
        chk("t5_restart_data", od[0], 0);
        wait_ready(0);

        // random traffic on both instances
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < 2; i++) begin
                cv[i] = ($urandom % 3) == 0;
                cl[i] = (($urandom % 60) == 0) ? 8'd255 : 8'($urandom_range(0, 6));
                st[i] = ($urandom % 4) == 0;
            end
            step();
        end
        for (int i = 0; i < 2; i++) begin
            cv[i] = 0; st[i] = 0;
        end
        wait_ready(0);
        wait_ready(1);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
